// File: rtl/multimem.sv
// multimem: 4096 x 8 write port / 2048 x 16 read port pseudo dual-port memory.
// Write port A stores one byte; read port B returns a little-endian 16-bit word
// (low byte at the even address). Reads are read-before-write.
// Optional feature macro: MULTIMEM_OUTREG_EN adds a second output register
// (2-cycle read latency) sharing ClockEnB and ResetN with the first.
module multimem #(
  parameter int unsigned ADDR_A_WIDTH = 12,
  parameter int unsigned ADDR_B_WIDTH = 11
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic                    ClockEnA,
  input  logic                    WrA,
  input  logic [ADDR_A_WIDTH-1:0] AddressA,
  input  logic [7:0]              DataInA,
  input  logic                    ClockEnB,
  input  logic [ADDR_B_WIDTH-1:0] AddressB,
  output logic [15:0]             QB
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned DEPTH_B = 2 ** ADDR_B_WIDTH;

  // Two byte lanes: even byte addresses in mem_lo, odd in mem_hi.
  // Zero initial contents apply to simulation; hardware power-up is undefined.
  logic [BYTE_W-1:0] mem_lo [DEPTH_B] = '{default: '0};
  logic [BYTE_W-1:0] mem_hi [DEPTH_B] = '{default: '0};

  logic                    wr_en_c;
  logic                    wr_hi_c;
  logic [ADDR_B_WIDTH-1:0] wr_idx_c;
  logic [WORD_W-1:0]       rd_word_c;

  logic [WORD_W-1:0]       rd_d;
  logic [WORD_W-1:0]       rd_q;

  // Decode the byte write into a lane select and word index.
  always_comb begin
    wr_en_c   = ResetN & ClockEnA & WrA;
    wr_hi_c   = AddressA[0];
    wr_idx_c  = ADDR_B_WIDTH'(AddressA >> 1);
    rd_word_c = {mem_hi[AddressB], mem_lo[AddressB]};
  end

  // Array write; no reset so contents survive ResetN.
  always_ff @(posedge Clock) begin
    if (wr_en_c) begin
      if (wr_hi_c) begin
        mem_hi[wr_idx_c] <= DataInA;
      end else begin
        mem_lo[wr_idx_c] <= DataInA;
      end
    end
  end

  // First read stage: load the addressed word when enabled, else hold.
  always_comb begin
    rd_d = rd_q;
    if (ClockEnB) begin
      rd_d = rd_word_c;
    end
  end

  // First read stage register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

`ifdef MULTIMEM_OUTREG_EN
  logic [WORD_W-1:0] out_d;
  logic [WORD_W-1:0] out_q;

  // Output stage: advances with the same enable as the array read.
  always_comb begin
    out_d = out_q;
    if (ClockEnB) begin
      out_d = rd_q;
    end
  end

  // Output stage register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign QB = out_q;
`else
  assign QB = rd_q;
`endif

endmodule

// File: tb/tb_multimem.sv
// Self-checking bench for multimem: directed vector table, hand sequences for
// hold/reset behaviour, and randomized traffic against a byte-array model.
module tb_multimem;

`ifdef MULTIMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        Clock;
  logic        ResetN;
  logic        ClockEnA;
  logic        WrA;
  logic [11:0] AddressA;
  logic [7:0]  DataInA;
  logic        ClockEnB;
  logic [10:0] AddressB;
  logic [15:0] QB;

  int checks = 0;
  int errors = 0;

  // Reference: flat byte memory plus the last LAT loaded words (oldest = QB).
  logic [7:0]  m [4096];
  logic [15:0] hist [$];

  typedef struct {
    logic        ena;
    logic        wra;
    logic [11:0] aa;
    logic [7:0]  da;
    logic        enb;
    logic [10:0] ab;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [13];

  multimem dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .ClockEnA (ClockEnA),
    .WrA      (WrA),
    .AddressA (AddressA),
    .DataInA  (DataInA),
    .ClockEnB (ClockEnB),
    .AddressB (AddressB),
    .QB       (QB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: QB=%h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_pipe();
    hist.delete();
    for (int k = 0; k < LAT; k++) hist.push_back(16'h0000);
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cycle(input logic ena, input logic wra, input logic [11:0] aa,
                       input logic [7:0] da, input logic enb, input logic [10:0] ab);
    ClockEnA = ena;
    WrA      = wra;
    AddressA = aa;
    DataInA  = da;
    ClockEnB = enb;
    AddressB = ab;
    @(posedge Clock);
    if (ResetN) begin
      if (enb) begin
        hist.push_back({m[{ab, 1'b1}], m[{ab, 1'b0}]});
        void'(hist.pop_front());
      end
      if (ena && wra) m[aa] = da;
    end
    @(negedge Clock);
    check("model", QB, hist[0]);
  endtask

  // Assert reset between edges, verify immediate clear, hold for n edges, release.
  task automatic do_reset(input int n);
    #2 ResetN = 1'b0;
    #1 check("reset_async", QB, 16'h0000);
    model_clear_pipe();
    for (int k = 0; k < n; k++)
      cycle(1'b1, 1'b1, 12'($urandom), 8'($urandom), 1'b1, 11'($urandom));
    ResetN = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) m[k] = 8'h00;
    model_clear_pipe();

    tbl[0]  = '{1'b1, 1'b1, 12'hFFF, 8'h41, 1'b1, 11'h7FF, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 12'hFFE, 8'h42, 1'b1, 11'h7FF, 16'h4100};
    tbl[2]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF, 16'h4142};
    tbl[3]  = '{1'b0, 1'b1, 12'hFFF, 8'h55, 1'b1, 11'h7FF, 16'h4142};
    tbl[4]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF, 16'h4142};
    tbl[5]  = '{1'b1, 1'b1, 12'hFFF, 8'h43, 1'b1, 11'h7FF, 16'h4142};
    tbl[6]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF, 16'h4342};
    tbl[7]  = '{1'b1, 1'b1, 12'hFFF, 8'h44, 1'b1, 11'h7FF, 16'h4342};
    tbl[8]  = '{1'b1, 1'b1, 12'hFFE, 8'h45, 1'b1, 11'h7FF, 16'h4442};
    tbl[9]  = '{1'b1, 1'b1, 12'hFFE, 8'h46, 1'b1, 11'h7FF, 16'h4445};
    tbl[10] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF, 16'h4446};
    tbl[11] = '{1'b1, 1'b0, 12'hFFE, 8'h00, 1'b1, 11'h7FF, 16'h4446};
    tbl[12] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF, 16'h4446};

    ResetN   = 1'b0;
    ClockEnA = 1'b0;
    WrA      = 1'b0;
    AddressA = '0;
    DataInA  = '0;
    ClockEnB = 1'b0;
    AddressB = '0;
    #1 check("reset_init", QB, 16'h0000);
    @(negedge Clock);
    cycle(1'b1, 1'b1, 12'h123, 8'hAA, 1'b1, 11'h091);
    cycle(1'b1, 1'b1, 12'hFFF, 8'hBB, 1'b1, 11'h7FF);
    ResetN = 1'b1;

    // Zero contents at start, including the words touched during reset.
    cycle(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h091);
    cycle(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF);
    for (int k = 0; k < 6; k++)
      cycle(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'($urandom));
    for (int k = 0; k < LAT; k++)
      cycle(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF);
    check("init_zero", QB, 16'h0000);

    // Directed vectors; exp is the word loaded on that edge, seen LAT-1 edges later.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].ena, tbl[i].wra, tbl[i].aa, tbl[i].da, tbl[i].enb, tbl[i].ab);
      if (i >= LAT - 1) check("table", QB, tbl[i - (LAT - 1)].exp);
    end

    // Hold with ClockEnB low while the address moves away.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 11'h000);
      check("hold", QB, 16'h4446);
    end

    // Mid-cycle reset clears QB at once; memory survives.
    do_reset(0);
    for (int k = 1; k <= LAT; k++) begin
      cycle(1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 11'h7FF);
      check("post_reset", QB, (k >= LAT) ? 16'h4446 : 16'h0000);
    end

    // Randomized traffic, biased toward the top words so reads and writes collide.
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] aa;
      logic [10:0] ab;
      aa = ($urandom_range(0, 1) == 0) ? (12'hFF0 | 12'($urandom_range(0, 15))) : 12'($urandom);
      ab = ($urandom_range(0, 1) == 0) ? (11'h7F8 | 11'($urandom_range(0, 7))) : 11'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, aa, 8'($urandom),
            $urandom_range(0, 3) != 0, ab);
      if (n % 700 == 350) do_reset($urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
